// File: rtl/min_index_seq.sv
// Sequential minimum-index finder: captures N_CH distances plus an enable mask on start,
// scans one channel per clock and reports the lowest-index minimum with a done pulse.
module min_index_seq #(
  parameter int N_CH   = 6,
  parameter int DATA_W = 8,
  parameter int IDX_W  = $clog2(N_CH)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [N_CH*DATA_W-1:0] data_in,
  input  logic [N_CH-1:0]        ch_mask,
  output logic                   busy,
  output logic                   done,
  output logic                   valid,
  output logic [IDX_W-1:0]       min_index,
  output logic [DATA_W-1:0]      min_value
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_CH - 1);
  localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

  state_t state_reg, state_next;

  logic [DATA_W-1:0] in_value  [N_CH];
  logic [DATA_W-1:0] cap_value [N_CH];
  logic [N_CH-1:0]   cap_mask;
  logic [IDX_W-1:0]  idx_reg;

  logic [DATA_W-1:0] best_value_reg;
  logic [IDX_W-1:0]  best_index_reg;
  logic              found_reg;

  logic [DATA_W-1:0] cur_value;
  logic              cur_take;
  logic [DATA_W-1:0] best_value_next;
  logic [IDX_W-1:0]  best_index_next;
  logic              found_next;
  logic              last_channel;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign in_value[gi] = data_in[gi*DATA_W +: DATA_W];
  end

  // Strict less-than keeps the earlier channel on a tie.
  assign cur_value    = cap_value[idx_reg];
  assign cur_take     = cap_mask[idx_reg] && (!found_reg || (cur_value < best_value_reg));
  assign last_channel = (idx_reg == LAST_IDX);

  always_comb begin
    best_value_next = best_value_reg;
    best_index_next = best_index_reg;
    found_next      = found_reg;
    if (cur_take) begin
      best_value_next = cur_value;
      best_index_next = idx_reg;
      found_next      = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = SCAN;
      SCAN:    if (last_channel) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int k = 0; k < N_CH; k++) begin
        cap_value[k] <= '0;
      end
      cap_mask       <= '0;
      idx_reg        <= '0;
      best_value_reg <= ALL_ONES;
      best_index_reg <= '0;
      found_reg      <= 1'b0;
      valid          <= 1'b0;
      min_index      <= '0;
      min_value      <= ALL_ONES;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            for (int k = 0; k < N_CH; k++) begin
              cap_value[k] <= in_value[k];
            end
            cap_mask       <= ch_mask;
            idx_reg        <= '0;
            best_value_reg <= ALL_ONES;
            best_index_reg <= '0;
            found_reg      <= 1'b0;
            valid          <= 1'b0;
          end
        end
        SCAN: begin
          best_value_reg <= best_value_next;
          best_index_reg <= best_index_next;
          found_reg      <= found_next;
          // Counter parks on the last channel instead of wrapping.
          if (last_channel) begin
            valid     <= found_next;
            min_index <= best_index_next;
            min_value <= best_value_next;
          end else begin
            idx_reg <= idx_reg + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_reg == SCAN);
  assign done = (state_reg == DONE);

endmodule

// File: tb/tb_min_index_seq.sv
// Self-checking bench for min_index_seq: directed and random operations on a 6x8 and a 5x12 instance.
module tb_min_index_seq;

  logic        clk;
  logic        rst_n;

  logic        start6, start5;
  logic [47:0] data6;
  logic [59:0] data5;
  logic [5:0]  mask6;
  logic [4:0]  mask5;
  logic        busy6, done6, valid6;
  logic        busy5, done5, valid5;
  logic [2:0]  idx6, idx5;
  logic [7:0]  val6;
  logic [11:0] val5;

  int errors = 0;
  int checks = 0;

  min_index_seq #(.N_CH(6), .DATA_W(8)) dut (
    .clock(clk), .reset(rst_n), .start(start6), .data_in(data6), .ch_mask(mask6),
    .busy(busy6), .done(done6), .valid(valid6), .min_index(idx6), .min_value(val6)
  );

  min_index_seq #(.N_CH(5), .DATA_W(12)) dut5 (
    .clock(clk), .reset(rst_n), .start(start5), .data_in(data5), .ch_mask(mask5),
    .busy(busy5), .done(done5), .valid(valid5), .min_index(idx5), .min_value(val5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: smallest enabled value, then the first enabled channel holding it.
  function automatic void ref_min(input int vals[6], input logic [5:0] mask, input int n,
                                  input int ones, output int e_idx, output int e_val,
                                  output bit e_vld);
    int en[$];
    bit got;
    e_idx = 0;
    e_val = ones;
    e_vld = 1'b0;
    got   = 1'b0;
    for (int k = 0; k < n; k++) if (mask[k]) en.push_back(vals[k]);
    if (en.size() > 0) begin
      en.sort();
      e_val = en[0];
      e_vld = 1'b1;
      for (int k = 0; k < n; k++) begin
        if (!got && mask[k] && vals[k] == e_val) begin
          e_idx = k;
          got   = 1'b1;
        end
      end
    end
  endfunction

  // Called at a negedge; start is taken on the next posedge (cycle 0).
  task automatic run_op(input int unit, input int vals[6], input logic [5:0] mask,
                        input bit disturb, input string tag);
    int n, ones, e_idx, e_val;
    bit e_vld;
    logic o_busy, o_done, o_valid;
    logic [31:0] o_idx, o_val;
    n    = (unit == 0) ? 6 : 5;
    ones = (unit == 0) ? 255 : 4095;
    ref_min(vals, mask, n, ones, e_idx, e_val, e_vld);
    if (unit == 0) begin
      for (int k = 0; k < 6; k++) data6[k*8 +: 8] = vals[k][7:0];
      mask6  = mask;
      start6 = 1'b1;
    end else begin
      for (int k = 0; k < 5; k++) data5[k*12 +: 12] = vals[k][11:0];
      mask5  = mask[4:0];
      start5 = 1'b1;
    end
    for (int c = 1; c <= n + 2; c++) begin
      @(negedge clk);
      start6 = 1'b0;
      start5 = 1'b0;
      o_busy  = (unit == 0) ? busy6 : busy5;
      o_done  = (unit == 0) ? done6 : done5;
      o_valid = (unit == 0) ? valid6 : valid5;
      o_idx   = (unit == 0) ? 32'(idx6) : 32'(idx5);
      o_val   = (unit == 0) ? 32'(val6) : 32'(val5);
      check($sformatf("%s.busy@%0d", tag, c), 32'(o_busy), 32'(c <= n));
      check($sformatf("%s.done@%0d", tag, c), 32'(o_done), 32'(c == n + 1));
      if (c == 1) check($sformatf("%s.valid_clr", tag), 32'(o_valid), 32'd0);
      if (c >= n + 1) begin
        check($sformatf("%s.valid@%0d", tag, c), 32'(o_valid), 32'(e_vld));
        check($sformatf("%s.index@%0d", tag, c), o_idx, 32'(e_idx));
        check($sformatf("%s.value@%0d", tag, c), o_val, 32'(e_val));
      end
      if (disturb) begin
        if (c == 1) begin
          data6 = ~data6;
          mask6 = ~mask6;
        end
        if (c == 2) start6 = 1'b1;
      end
    end
    $display("op %s: mask=%b index=%0d value=%0d valid=%0d", tag, mask, e_idx, e_val, e_vld);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".busy6"},  32'(busy6),  32'd0);
    check({tag, ".done6"},  32'(done6),  32'd0);
    check({tag, ".valid6"}, 32'(valid6), 32'd0);
    check({tag, ".index6"}, 32'(idx6),   32'd0);
    check({tag, ".value6"}, 32'(val6),   32'd255);
    check({tag, ".busy5"},  32'(busy5),  32'd0);
    check({tag, ".done5"},  32'(done5),  32'd0);
    check({tag, ".valid5"}, 32'(valid5), 32'd0);
    check({tag, ".index5"}, 32'(idx5),   32'd0);
    check({tag, ".value5"}, 32'(val5),   32'd4095);
  endtask

  initial begin
    int v[6];
    logic [5:0] m;

    rst_n  = 1'b0;
    start6 = 1'b0;
    start5 = 1'b0;
    data6  = '0;
    data5  = '0;
    mask6  = '0;
    mask5  = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    $display("reset: outputs checked");
    rst_n = 1'b1;
    @(negedge clk);

    v = '{40, 12, 33, 90, 12, 7};
    run_op(0, v, 6'h3F, 1'b0, "basic");

    v = '{20, 5, 5, 1, 9, 9};
    run_op(0, v, 6'b110110, 1'b0, "tie_mask");

    v = '{3, 1, 4, 1, 5, 9};
    run_op(0, v, 6'h00, 1'b0, "empty");

    v = '{50, 60, 70, 80, 45, 99};
    run_op(0, v, 6'h3F, 1'b1, "disturb");

    // Reset in the middle of a scan: state returns to IDLE with no done pulse.
    v = '{9, 8, 7, 6, 5, 4};
    for (int k = 0; k < 6; k++) data6[k*8 +: 8] = v[k][7:0];
    mask6  = 6'h3F;
    start6 = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      start6 = 1'b0;
    end
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("midreset.no_done@%0d", c), 32'(done6), 32'd0);
      check($sformatf("midreset.no_busy@%0d", c), 32'(busy6), 32'd0);
    end
    $display("midreset: abort checked");
    run_op(0, v, 6'h3F, 1'b0, "after_reset");

    v = '{4095, 4000, 4001, 3999, 4095, 0};
    run_op(1, v, 6'h1F, 1'b0, "param5");

    for (int t = 0; t < 20; t++) begin
      for (int k = 0; k < 6; k++) v[k] = (t % 2 == 0) ? $urandom_range(0, 7) : $urandom_range(0, 255);
      m = 6'($urandom);
      if (t % 5 == 0) m = 6'h3F;
      run_op(0, v, m, 1'b0, $sformatf("rand6_%0d", t));
    end

    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 6; k++) v[k] = (t % 2 == 0) ? $urandom_range(4090, 4095) : $urandom_range(0, 4095);
      m = 6'($urandom);
      run_op(1, v, m, 1'b0, $sformatf("rand5_%0d", t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/min_index_seq.md
Name: min_index_seq

Overview:
- Parametrised, sequential successor to the 6-way combinational minimum-index encoder used in colour classification.
- Captures N_CH unsigned distance values in parallel, plus a per-channel enable mask, on a start pulse.
- Scans the captured values one channel per clock and reports the index and value of the minimum, with a done pulse.
- Sits between the colour-distance calculators and the facelet classification/controller FSM.

Parameters:
- N_CH, 6, number of channels compared (minimum 2).
- DATA_W, 8, width of each unsigned distance value.
- IDX_W, $clog2(N_CH), width of the index output.

Ports:
- clock  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the rising edge of clock.
- start  input  1  request pulse; honoured only in IDLE.
- data_in  input  N_CH*DATA_W  packed values; channel k occupies bits [k*DATA_W +: DATA_W].
- ch_mask  input  N_CH  bit k=1 means channel k takes part in the comparison.
- busy  output  1  high while the block is in SCAN.
- done  output  1  single-cycle pulse when the result is valid.
- valid  output  1  1 if at least one channel was enabled in the last completed operation.
- min_index  output  IDX_W  index of the minimum enabled channel.
- min_value  output  DATA_W  value of that channel.

Behaviour:
- Reset (reset=0 at a clock edge):
  - state goes to IDLE;
  - busy=0, done=0, valid=0, min_index=0, min_value={DATA_W{1'b1}};
  - internal index counter and capture registers are cleared.
  - Reset takes priority over every other input, including mid-SCAN: the operation is aborted and no done pulse is produced.
- States:
  - IDLE -> SCAN on start=1.
  - SCAN -> DONE after channel N_CH-1 has been processed.
  - DONE -> IDLE unconditionally after one cycle.
- IDLE:
  - On an edge with start=1: register data_in and ch_mask, set the scan index to 0, set the running best to "none", clear valid, go to SCAN.
  - Outputs from the previous operation are held until that start edge.
- SCAN, one channel per edge at index i:
  - If ch_mask[i]=1 and (best is none, or value[i] < best_value): best_value <= value[i], best_index <= i, found <= 1.
  - Comparison is strict unsigned less-than, so on a tie the lowest index wins.
  - Masked channels are skipped but still consume their cycle; the scan length is fixed.
  - At i=N_CH-1, after the update: go to DONE and register min_index, min_value and valid from best/found.
- DONE: done=1 for exactly one cycle; busy=0.
- Latency: with the start edge at cycle 0, done is high during cycle N_CH+1. Back-to-back throughput is one result per N_CH+2 cycles.
- start while in SCAN or DONE: ignored; it is not queued. data_in and ch_mask changes after the capture edge have no effect.
- All channels masked (ch_mask=0): valid=0, min_index=0, min_value=all ones; done still pulses at the normal time.
- busy=1 exactly during the N_CH SCAN cycles.
- The index counter is IDX_W bits and never wraps past N_CH-1, including for non-power-of-two N_CH.

Test Plan (N_CH=6, DATA_W=8 unless noted):
- Basic: data {ch0..ch5}={40,12,33,90,12,7}, mask=6'h3F, start at cycle 0 -> busy for cycles 1..6, done high in cycle 7 only, min_index=5, min_value=7, valid=1.
- Tie and mask: data {20,5,5,1,9,9}, mask=6'b110110 (ch0 and ch3 disabled) -> min_index=1, min_value=5 (lowest index wins the tie, and disabled ch3 is ignored).
- Empty mask: mask=0, any data -> done in cycle 7, valid=0, min_index=0, min_value=8'hFF.
- Start during busy, and input change: pulse start at cycle 3 and change data_in at cycle 2 -> single done in cycle 7, result taken from the data captured at cycle 0, no second operation starts.
- Reset mid-op: assert reset=0 at cycle 4 of a scan -> next cycle state is IDLE with all outputs at reset values and no done pulse; a new start then completes normally.
- Parametric: N_CH=5, DATA_W=12, data {4095,4000,4001,3999,4095}, mask all ones -> done 6 cycles after the start edge, min_index=3, min_value=3999.
